beam_feeder: RTL

BEAM_FEEDER -- requirements
Module: beam_feeder

---
 rtl/aoc7_pkg.sv | 21 ++
 rtl/drain_accumulator.sv | 54 +++++
 rtl/beam_feeder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/aoc7_pkg.sv
// Shared constants and state encoding for the beam-splitter feed path.
// DATA_WIDTH is a project-wide macro; it gets a fallback here so this slice builds standalone.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

package aoc7_pkg;

  typedef enum logic [1:0] {
    ST_FEED  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [7:0] CHAR_SPLIT = 8'h5E;
  localparam logic [7:0] CHAR_NL    = 8'h0A;
  localparam logic [7:0] CHAR_CR    = 8'h0D;

  localparam int SUM_WIDTH_DEF = 64;

endpackage

// File: rtl/drain_accumulator.sv
// Runs LINE_LENGTH drain cycles after a start pulse, summing count_in on each one.
// run_next is the next-cycle drain flag so the parent can register en_out from it.
module drain_accumulator
  import aoc7_pkg::*;
#(
  parameter int LINE_LENGTH = 141,
  parameter int SUM_WIDTH   = SUM_WIDTH_DEF,
  parameter int DATA_WIDTH  = `DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] count_in,
  output logic                  run_next,
  output logic                  last_cycle,
  output logic [SUM_WIDTH-1:0]  sum
);

  localparam int CNT_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_LENGTH - 1);

  logic                 run_q, run_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;

  assign last_cycle = run_q && (cnt_q == CNT_LAST);

  always_comb begin
    run_d = start || (run_q && !last_cycle);
    cnt_d = '0;
    sum_d = sum_q;
    if (run_q) begin
      cnt_d = last_cycle ? '0 : cnt_q + CNT_W'(1);
      // Zero-extend (or truncate) the column count; the sum wraps naturally.
      sum_d = sum_q + SUM_WIDTH'(count_in);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      sum_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
    end
  end

  assign run_next = run_d;
  assign sum      = sum_q;

endmodule

// File: rtl/beam_feeder.sv
// Turns the puzzle byte stream into one splitter cell per cycle, then drains the
// splitter timeline for one line and reports the accumulated column counts.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// ST_FEED  | accepting bytes, pulsing en_out once per grid cell
// ST_DRAIN | input closed; LINE_LENGTH empty cells push counts out of splitter
// ST_DONE  | sum_out final and held until reset
module beam_feeder
  import aoc7_pkg::*;
#(
  parameter int LINE_LENGTH = 141,
  parameter int SUM_WIDTH   = SUM_WIDTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  input  logic                   byte_last,
  output logic                   byte_ready,
  output logic                   split_out,
  output logic                   en_out,
  input  logic [`DATA_WIDTH-1:0] count_in,
  output logic [SUM_WIDTH-1:0]   sum_out,
  output logic                   sum_valid,
  output logic                   col_err
);

  localparam int COL_W = $clog2(LINE_LENGTH + 2);
  localparam logic [COL_W-1:0] COL_LEN = COL_W'(LINE_LENGTH);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(LINE_LENGTH + 1);

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             en_q, en_d;
  logic             split_q, split_d;
  logic             col_err_q, col_err_d;
  logic             sum_valid_q, sum_valid_d;
  logic             pend_q, pend_d;

  logic accept, is_cell, cell_acc, last_acc, nl_err;
  logic acc_start, acc_run_next, acc_last_cycle;

  always_comb begin
    accept   = byte_valid && (state_q == ST_FEED);
    is_cell  = (byte_data != CHAR_NL) && (byte_data != CHAR_CR);
    cell_acc = accept && is_cell;
    last_acc = accept && byte_last;

    col_d  = col_q;
    nl_err = 1'b0;
    if (cell_acc && (col_q != COL_MAX)) col_d = col_q + COL_W'(1);
    if (accept && (byte_data == CHAR_NL)) begin
      nl_err = (col_q != COL_LEN);
      col_d  = '0;
    end

    // A final line without its newline is judged on the post-byte column.
    col_err_d = col_err_q || nl_err ||
                (last_acc && (col_d != '0) && (col_d != COL_LEN));

    // If the last byte is a cell its pulse goes first; drain starts one cycle later.
    pend_d    = last_acc && is_cell;
    acc_start = (last_acc && !is_cell) || pend_q;

    en_d    = cell_acc || acc_run_next;
    split_d = cell_acc && (byte_data == CHAR_SPLIT);

    state_d = state_q;
    case (state_q)
      ST_FEED:  if (last_acc) state_d = ST_DRAIN;
      ST_DRAIN: if (acc_last_cycle) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_FEED;
    endcase

    sum_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_FEED;
      col_q       <= '0;
      en_q        <= 1'b0;
      split_q     <= 1'b0;
      col_err_q   <= 1'b0;
      sum_valid_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      en_q        <= en_d;
      split_q     <= split_d;
      col_err_q   <= col_err_d;
      sum_valid_q <= sum_valid_d;
      pend_q      <= pend_d;
    end
  end

  drain_accumulator #(
    .LINE_LENGTH (LINE_LENGTH),
    .SUM_WIDTH   (SUM_WIDTH),
    .DATA_WIDTH  (`DATA_WIDTH)
  ) u_drain (
    .clock      (clock),
    .reset      (reset),
    .start      (acc_start),
    .count_in   (count_in),
    .run_next   (acc_run_next),
    .last_cycle (acc_last_cycle),
    .sum        (sum_out)
  );

  assign byte_ready = (state_q == ST_FEED);
  assign en_out     = en_q;
  assign split_out  = split_q;
  assign sum_valid  = sum_valid_q;
  assign col_err    = col_err_q;

endmodule
